// File: rtl/uart_rx_frontend.sv
// UART receiver front end: synchronises an asynchronous 8N1 line (optional parity),
// rejects start-bit glitches, reports framing/parity/overrun errors, and holds each byte for a valid/ready consumer.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] Extracted_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       receive_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  // state  | meaning
  // IDLE   | waiting for a falling edge on the synchronised line
  // START  | counting to mid start bit; high there means a glitch
  // DATA   | sampling 8 data bits LSB first at mid bit
  // PARITY | sampling the parity bit and latching a mismatch flag
  // STOP   | sampling the stop bit, then deliver or report an error
  // BREAK  | line stuck low after a framing error; wait for idle high
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             par_bad;
  logic             rx_m, rx_s, rx_prev;
  logic             fall;

  assign fall = rx_prev & ~rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m           <= 1'b1;
      rx_s           <= 1'b1;
      rx_prev        <= 1'b1;
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      par_bad        <= 1'b0;
      Extracted_data <= '0;
      rx_valid       <= 1'b0;
      receive_done   <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      rx_m         <= rx;
      rx_s         <= rx_m;
      rx_prev      <= rx_s;
      receive_done <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;

      // A delivery on this same edge overrides the clear below.
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            clk_cnt <= '0;
            par_bad <= 1'b0;
          end
        end

        START: begin
          if (clk_cnt == HALF_LAST) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              clk_cnt <= '0;
              bit_idx <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7)
              state <= PARITY_EN ? PARITY : STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            par_bad <= ((^shift) ^ rx_s) != PARITY_ODD;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else if (par_bad) begin
              parity_err <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= IDLE;
              if (!rx_valid || rx_ready) begin
                Extracted_data <= shift;
                rx_valid       <= 1'b1;
                receive_done   <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        BREAK: begin
          if (rx_s)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
